// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS multicycle register file.
// Named register addresses are provided for benches and surrounding datapath code.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_wr_decode.sv
// Write-address decoder: ADDR_W-bit address to NREGS one-hot enables, gated by en_i.
// Bit 0 is always low so r0 can never be written.
module regfile_wr_decode #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NREGS-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
        onehot_o[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_32x32_wr.sv
// 32x32 register file: one synchronous write port, two combinational read ports, r0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_32x32_wr #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    import regfile_pkg::*;

    // r0 has no storage; the array starts at index 1.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];
    logic [NREGS-1:0]  we_onehot;
    logic              unused_we_bit0;

    regfile_wr_decode #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_wr_decode (
        .en_i     (regWrite),
        .addr_i   (writeReg),
        .onehot_o (we_onehot)
    );

    assign unused_we_bit0 = we_onehot[0];

    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_onehot[i]) begin
                regs_d[i] = writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic fwd1;
    logic fwd2;

    assign wr_live = regWrite && !reset && (writeReg != ADDR_W'(REG_ZERO));
    assign fwd1    = wr_live && (readReg1 == writeReg);
    assign fwd2    = wr_live && (readReg2 == writeReg);
`else
    logic fwd1;
    logic fwd2;

    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        readData1 = '0;
        if (fwd1) begin
            readData1 = writeData;
        end else if (readReg1 != ADDR_W'(REG_ZERO)) begin
            readData1 = regs_q[readReg1];
        end
    end

    always_comb begin
        readData2 = '0;
        if (fwd2) begin
            readData2 = writeData;
        end else if (readReg2 != ADDR_W'(REG_ZERO)) begin
            readData2 = regs_q[readReg2];
        end
    end

endmodule

// File: tb/tb_regfile_32x32_wr.sv
// Self-checking bench for regfile_32x32_wr: directed cases then randomized cycles against an array model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_32x32_wr;

    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];

    regfile_32x32_wr dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a read port should show before the edge, given the write currently presented.
    function automatic logic [31:0] pre_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : mem[a];
`ifdef REGFILE_BYPASS_EN
        if (regWrite && !reset && writeReg != 5'd0 && a == writeReg) v = writeData;
`endif
        return v;
    endfunction

    // Apply one cycle of inputs, check reads before and after the rising edge.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input string tag);
        reset = rst; regWrite = we; writeReg = wr; writeData = wd;
        readReg1 = r1; readReg2 = r2;
        #1;
        check({tag, ".pre1"}, readData1, pre_read(r1));
        check({tag, ".pre2"}, readData2, pre_read(r2));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            mem[wr] = wd;
        end
        #1;
        reset = 1'b0; regWrite = 1'b0;
        #1;
        check({tag, ".post1"}, readData1, mem[r1]);
        check({tag, ".post2"}, readData2, mem[r2]);
    endtask

    // Read every address on both ports with no write pending.
    task automatic sweep(input string tag);
        reset = 1'b0; regWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            readReg1 = 5'(a);
            readReg2 = 5'(31 - a);
            @(negedge clk);
            check($sformatf("%s.p1[%0d]", tag, a), readData1, mem[a]);
            check($sformatf("%s.p2[%0d]", tag, 31 - a), readData2, mem[31 - a]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] old14;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sweep("reset_init");

        // Reset clear after a real write.
        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "wr5");
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rst_clear");
        check("rst_r5", readData1, 32'h0000_0000);
        sweep("after_reset");

        // Basic write / read on both ports.
        cyc(1'b0, 1'b1, 5'd7, 32'h0451ABCD, 5'd7, 5'd7, "wr7");
        check("r7_p1", readData1, 32'h0451ABCD);
        check("r7_p2", readData2, 32'h0451ABCD);

        // Write enable low holds the prior value.
        cyc(1'b0, 1'b1, 5'd9, 32'h1451ABCF, 5'd9, 5'd7, "wr9");
        cyc(1'b0, 1'b0, 5'd9, 32'h12345678, 5'd9, 5'd9, "we_low");
        check("r9_hold", readData1, 32'h1451ABCF);

        // r0 write ignored; nothing else disturbed.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
        check("r0_zero", readData1, 32'h0);
        sweep("after_r0");

        // Read-during-write on r14.
        cyc(1'b0, 1'b1, 5'd14, 32'h0123AEFD, 5'd14, 5'd14, "wr14a");
        reset = 1'b0; regWrite = 1'b1; writeReg = 5'd14; writeData = 32'h1456EDCF;
        readReg1 = 5'd0; readReg2 = 5'd14;
        #1;
`ifdef REGFILE_BYPASS_EN
        old14 = 32'h1456EDCF;
`else
        old14 = 32'h0123AEFD;
`endif
        check("rdw_pre", readData2, old14);
        check("rdw_r0", readData1, 32'h0);
        cyc(1'b0, 1'b1, 5'd14, 32'h1456EDCF, 5'd0, 5'd14, "wr14b");
        check("rdw_post", readData2, 32'h1456EDCF);

        // Reset wins over a same-edge write.
        cyc(1'b0, 1'b1, 5'd31, 32'h13572468, 5'd31, 5'd29, "wr31");
        cyc(1'b1, 1'b1, 5'd31, 32'hAAAA5555, 5'd31, 5'd14, "rst_prio");
        check("r31_rst", readData1, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $sformatf("rnd%0d", n));
        end
        sweep("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
